fetch_stage: RTL

Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode-stage control unit.
- Owns the PC and issues word reads to instruction memory over a one-outstanding request/response interface.
- Absorbs stalls from decode with a one-entry skid buffer.
- Presents the instruction, its PC and the opcode field (instr[6:0]) to decode.
- Applies EX-stage redirects (taken branch, jump) by flushing and discarding stale responses.

---
 rtl/fetch_stage_pkg.sv | 23 ++
 rtl/fetch_skid_buf.sv | 39 +++
 rtl/fetch_stage.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and the decode-stage control unit:
// bubble encoding, base opcode values and the fetch FSM state encoding.
package fetch_stage_pkg;

  // addi x0, x0, 0 -- the canonical bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Opcode field values (instr[6:0]) understood by the control unit
  localparam logic [6:0] ALU_R      = 7'h33;
  localparam logic [6:0] ALU_I      = 7'h13;
  localparam logic [6:0] BRANCH_EQ  = 7'h63;
  localparam logic [6:0] JUMP       = 7'h6F;
  localparam logic [6:0] LOAD_WORD  = 7'h03;
  localparam logic [6:0] STORE_WORD = 7'h23;

  // IDLE: nothing outstanding; WAIT: live request; DISCARD: stale request
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer that catches the single in-flight
// response arriving while decode is stalled.
module fetch_skid_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              load,
  input  logic              pop,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_instr,
  input  logic [DATA_W-1:0] load_pc,
  output logic              full,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] pc
);

  // Occupancy flag: clear (redirect) beats load, load beats pop
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  // Payload; only meaningful while full, so it carries no reset
  always_ff @(posedge clk) begin
    if (load && !clear) begin
      instr <= load_instr;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps one read outstanding to instruction
// memory, buffers one response across decode stalls and applies EX redirects.
module fetch_stage #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(fetch_stage_pkg::NOP_INSTR)
) (
  input  logic              clk,
  input  logic              arst_n,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              id_stall,
  input  logic              redirect_valid,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic              if_id_valid,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [DATA_W-1:0] if_id_pc,
  output logic [6:0]        opcode
);
  import fetch_stage_pkg::*;

  localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

  function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] a);
    return {a[DATA_W-1:2], 2'b00};
  endfunction

  fetch_state_t      state, state_d;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] req_pc;
  logic              resp;
  logic              issue;
  logic              skid_full, skid_load, skid_pop, skid_clear;
  logic [DATA_W-1:0] skid_instr, skid_pc;

  // A live response; responses seen in DISCARD are never used
  assign resp  = (state == WAIT) && imem_rvalid;
  // New request only when the memory slot frees up and there is room to land it
  assign issue = arst_n && !redirect_valid && !skid_full &&
                 ((state == IDLE) || (resp && !id_stall));

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign opcode    = if_id_instr[6:0];

  assign skid_clear = redirect_valid;
  assign skid_load  = !redirect_valid && id_stall && resp;
  assign skid_pop   = !redirect_valid && !id_stall && skid_full;

  fetch_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk        (clk),
    .arst_n     (arst_n),
    .load       (skid_load),
    .pop        (skid_pop),
    .clear      (skid_clear),
    .load_instr (imem_rdata),
    .load_pc    (req_pc),
    .full       (skid_full),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  // Next-state: redirect turns a live request stale unless its data is arriving now
  always_comb begin
    state_d = state;
    if (redirect_valid) begin
      if (state != IDLE) begin
        state_d = imem_rvalid ? IDLE : DISCARD;
      end
    end else if (issue) begin
      state_d = WAIT;
    end else if ((state != IDLE) && imem_rvalid) begin
      state_d = IDLE;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Program counter: redirect target (word aligned) or sequential advance on issue
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= word_align(redirect_pc);
    end else if (issue) begin
      pc_q <= pc_q + PC_STEP;
    end
  end

  // Address of the outstanding request, paired with its returning data
  always_ff @(posedge clk) begin
    if (issue) begin
      req_pc <= pc_q;
    end
  end

  // IF/ID register: flush on redirect, hold on stall, else skid > memory > bubble
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
    end else if (redirect_valid) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else if (!id_stall) begin
      if (skid_full) begin
        if_id_valid <= 1'b1;
        if_id_instr <= skid_instr;
        if_id_pc    <= skid_pc;
      end else if (resp) begin
        if_id_valid <= 1'b1;
        if_id_instr <= imem_rdata;
        if_id_pc    <= req_pc;
      end else begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end
    end
  end

endmodule
